// File: rtl/vga_view_pkg.sv
// Shared types and helpers for the VGA memory-window viewer.
package vga_view_pkg;

    localparam int unsigned BYTES         = 32;
    localparam int unsigned BYTES_PER_ROW = 4;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned WIN_W         = BYTES * BITS_PER_BYTE;
    localparam int unsigned IDX_W         = $clog2(BYTES);
    localparam int unsigned COL_W         = $clog2(BYTES_PER_ROW);
    localparam int unsigned BIT_W         = $clog2(BITS_PER_BYTE);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAW
    } state_t;

    // Byte k lives in the most-significant end first: bits [255-8k -: 8].
    function automatic logic [7:0] byte_base(input logic [IDX_W-1:0] k);
        return {~k, 3'b000};
    endfunction

    function automatic logic [BITS_PER_BYTE-1:0] get_byte(input logic [WIN_W-1:0] v,
                                                          input logic [IDX_W-1:0] k);
        return v[byte_base(k) +: BITS_PER_BYTE];
    endfunction

endpackage

// File: rtl/vga_cell_counter.sv
// Nested pixel walker for one byte: bit column outer, cell row, cell column innermost.
module vga_cell_counter
    import vga_view_pkg::*;
#(
    parameter int unsigned CELL = 4,
    parameter int unsigned CW   = (CELL > 1) ? $clog2(CELL) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             en,
    output logic [BIT_W-1:0] bit_col,
    output logic [CW-1:0]    py,
    output logic [CW-1:0]    px,
    output logic             last_c
);

    localparam logic [CW-1:0]    CELL_MAX = CW'(CELL - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(BITS_PER_BYTE - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_col <= '0;
            py      <= '0;
            px      <= '0;
        end else if (clear) begin
            bit_col <= '0;
            py      <= '0;
            px      <= '0;
        end else if (en) begin
            if (px == CELL_MAX) begin
                px <= '0;
                if (py == CELL_MAX) begin
                    py      <= '0;
                    bit_col <= bit_col + BIT_W'(1);
                end else begin
                    py <= py + CW'(1);
                end
            end else begin
                px <= px + CW'(1);
            end
        end
    end

    assign last_c = (bit_col == BIT_MAX) && (py == CELL_MAX) && (px == CELL_MAX);

endmodule

// File: rtl/vga_mem_viewer.sv
// Mirrors the 32-byte memory window onto the VGA adapter as a grid of coloured
// bit cells, repainting only bytes that differ from what is already on screen.
module vga_mem_viewer
    import vga_view_pkg::*;
#(
    parameter int unsigned CELL = 4,
    parameter int unsigned X0   = 16,
    parameter int unsigned Y0   = 44,
    parameter logic [2:0]  FG   = 3'b111,
    parameter logic [2:0]  BG   = 3'b000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIN_W-1:0] memory_first_32_bytes,
    input  logic             refresh,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       colour,
    output logic             plot,
    output logic             busy
);

    localparam int unsigned      CW       = (CELL > 1) ? $clog2(CELL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t                   state;
    state_t                   state_next;
    logic [IDX_W-1:0]         byte_idx;
    logic [WIN_W-1:0]         frame;
    logic [WIN_W-1:0]         shadow;
    logic                     refresh_pending;
    logic                     force_all;

    logic [BIT_W-1:0]         bit_col;
    logic [CW-1:0]            py;
    logic [CW-1:0]            px;
    logic                     last_c;

    logic                     launch;
    logic                     cnt_clear;
    logic                     cnt_en;
    logic                     idx_inc;
    logic                     commit;
    logic [BITS_PER_BYTE-1:0] frame_byte;
    logic [BITS_PER_BYTE-1:0] shadow_byte;
    logic [31:0]              x_full;
    logic [31:0]              y_full;

    assign frame_byte  = get_byte(frame, byte_idx);
    assign shadow_byte = get_byte(shadow, byte_idx);

    vga_cell_counter #(
        .CELL (CELL),
        .CW   (CW)
    ) u_cell_counter (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .bit_col (bit_col),
        .py      (py),
        .px      (px),
        .last_c  (last_c)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        idx_inc    = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (refresh_pending || (memory_first_32_bytes != shadow)) begin
                    launch     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (force_all || (frame_byte != shadow_byte)) begin
                    cnt_clear  = 1'b1;
                    state_next = DRAW;
                end else if (byte_idx == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                if (last_c) begin
                    commit = 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = SCAN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame snapshot, on-screen shadow, byte pointer and refresh bookkeeping.
    // A refresh arriving on the launch edge wins so it is kept for the next pass.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_idx        <= '0;
            frame           <= '0;
            shadow          <= '0;
            refresh_pending <= 1'b1;
            force_all       <= 1'b0;
        end else begin
            if (refresh) begin
                refresh_pending <= 1'b1;
            end else if (launch) begin
                refresh_pending <= 1'b0;
            end
            if (launch) begin
                frame     <= memory_first_32_bytes;
                force_all <= refresh_pending;
                byte_idx  <= '0;
            end else if (idx_inc) begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
            if (commit) begin
                shadow[byte_base(byte_idx) +: BITS_PER_BYTE] <= frame_byte;
            end
        end
    end

    // Pixel coordinates at full width, then truncated to the adapter's port widths.
    always_comb begin
        x_full = X0
               + 32'(byte_idx[COL_W-1:0]) * (BITS_PER_BYTE * CELL)
               + 32'(bit_col) * CELL
               + 32'(px);
        y_full = Y0
               + 32'(byte_idx[IDX_W-1:COL_W]) * CELL
               + 32'(py);
    end

    assign x      = 8'(x_full);
    assign y      = 7'(y_full);
    assign colour = frame_byte[~bit_col] ? FG : BG;
    assign plot   = (state == DRAW);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_vga_mem_viewer.sv
// Scoreboard bench for vga_mem_viewer: expected pixel streams are queued per pass
// and popped as the DUT plots.
module tb_vga_mem_viewer;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic         clk;
    logic         resetn;
    logic         refresh;
    logic [255:0] mem;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot;
    logic         busy;

    int           checks;
    int           failures;
    pix_t         exp_q[$];
    logic [255:0] model_shadow;

    vga_mem_viewer dut (
        .clk                   (clk),
        .resetn                (resetn),
        .memory_first_32_bytes (mem),
        .refresh               (refresh),
        .x                     (x),
        .y                     (y),
        .colour                (colour),
        .plot                  (plot),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pix_t mk_pix(input int px_x, input int px_y, input int c);
        pix_t p;
        p.x = 8'(px_x);
        p.y = 7'(px_y);
        p.c = 3'(c);
        return p;
    endfunction

    function automatic logic [255:0] set_byte(input logic [255:0] v, input int k, input logic [7:0] b);
        logic [255:0] r;
        r = v;
        r[255-8*k -: 8] = b;
        return r;
    endfunction

    // Queue the pixels one pass should draw, given the model's idea of the screen.
    task automatic push_pass(input logic [255:0] frm, input bit force_all);
        logic [7:0] fb;
        logic [7:0] sb;
        for (int k = 0; k < 32; k++) begin
            fb = frm[255-8*k -: 8];
            sb = model_shadow[255-8*k -: 8];
            if (force_all || (fb != sb)) begin
                for (int c = 0; c < 8; c++)
                    for (int py = 0; py < 4; py++)
                        for (int px = 0; px < 4; px++)
                            exp_q.push_back(mk_pix(16 + (k % 4) * 32 + c * 4 + px,
                                                   44 + (k / 4) * 4 + py,
                                                   fb[7-c] ? 7 : 0));
                model_shadow[255-8*k -: 8] = fb;
            end
        end
    endtask

    // Run until the DUT has been idle for 4 samples, comparing each plotted pixel.
    task automatic observe(input string name, input int max_cycles, input int act_cycle,
                           input int act_y, input logic [255:0] act_mem, input bit act_refresh,
                           output int plots, output int bcyc, output pix_t fp, output pix_t lp);
        int   quiet;
        bit   acted;
        bit   pulse;
        pix_t got;
        pix_t exp;
        plots = 0;
        bcyc  = 0;
        quiet = 0;
        acted = 1'b0;
        pulse = 1'b0;
        fp    = '0;
        lp    = '0;
        for (int cyc = 0; cyc < max_cycles && quiet < 4; cyc++) begin
            @(negedge clk);
            if (pulse) begin
                refresh = 1'b0;
                pulse   = 1'b0;
            end
            if (busy === 1'b1) begin
                bcyc++;
                quiet = 0;
            end else begin
                quiet++;
            end
            if (plot === 1'b1) begin
                got = pix_t'({x, y, colour});
                if (plots == 0) fp = got;
                lp = got;
                plots++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_plot got x=%0d y=%0d c=%0d required none",
                             name, got.x, got.y, got.c);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL %s pixel#%0d got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                                 name, plots - 1, got.x, got.y, got.c, exp.x, exp.y, exp.c);
                    end
                end
            end
            if (!acted && ((cyc == act_cycle) || (act_y >= 0 && plot === 1'b1 && int'(y) == act_y))) begin
                acted = 1'b1;
                mem   = act_mem;
                if (act_refresh) begin
                    refresh = 1'b1;
                    pulse   = 1'b1;
                end
            end
        end
        checks++;
        if (quiet < 4) begin
            failures++;
            $display("FAIL %s timeout got busy_cycles=%0d required idle within %0d cycles",
                     name, bcyc, max_cycles);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_pixels got %0d left required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int   plots;
        int   bcyc;
        pix_t fp;
        pix_t lp;
        resetn  = 1'b0;
        refresh = 1'b0;
        mem     = '0;
        repeat (3) @(negedge clk);
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got %b required 0", plot); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (x !== 8'd16) begin failures++; $display("FAIL reset_x got %0d required 16", x); end
        checks++; if (y !== 7'd44) begin failures++; $display("FAIL reset_y got %0d required 44", y); end
        checks++; if (colour !== 3'd0) begin failures++; $display("FAIL reset_colour got %0d required 0", colour); end
        model_shadow = '0;
        push_pass(mem, 1'b1);
        resetn = 1'b1;
        observe("reset_pass", 6000, -1, -1, mem, 1'b0, plots, bcyc, fp, lp);
        checks++; if (plots != 4096) begin failures++; $display("FAIL reset_pass_plots got %0d required 4096", plots); end
        checks++; if (bcyc != 4128) begin failures++; $display("FAIL reset_pass_busy got %0d required 4128", bcyc); end
        checks++; if (fp !== mk_pix(16, 44, 0)) begin failures++; $display("FAIL reset_first got x=%0d y=%0d required 16,44", fp.x, fp.y); end
        checks++; if (lp !== mk_pix(143, 75, 0)) begin failures++; $display("FAIL reset_last got x=%0d y=%0d required 143,75", lp.x, lp.y); end
    endtask

    task automatic test_byte_change();
        int   plots;
        int   bcyc;
        pix_t fp;
        pix_t lp;
        mem = set_byte(mem, 5, 8'h81);
        push_pass(mem, 1'b0);
        observe("byte5", 1000, -1, -1, mem, 1'b0, plots, bcyc, fp, lp);
        checks++; if (plots != 128) begin failures++; $display("FAIL byte5_plots got %0d required 128", plots); end
        checks++; if (bcyc != 160) begin failures++; $display("FAIL byte5_busy got %0d required 160", bcyc); end
        checks++; if (fp !== mk_pix(48, 48, 7)) begin failures++; $display("FAIL byte5_first got x=%0d y=%0d c=%0d required 48,48,7", fp.x, fp.y, fp.c); end
        checks++; if (lp !== mk_pix(79, 51, 7)) begin failures++; $display("FAIL byte5_last got x=%0d y=%0d c=%0d required 79,51,7", lp.x, lp.y, lp.c); end
    endtask

    task automatic test_refresh();
        int   plots;
        int   bcyc;
        pix_t fp;
        pix_t lp;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        push_pass(mem, 1'b1);
        observe("refresh", 6000, -1, -1, mem, 1'b0, plots, bcyc, fp, lp);
        checks++; if (plots != 4096) begin failures++; $display("FAIL refresh_plots got %0d required 4096", plots); end
        checks++; if (bcyc != 4128) begin failures++; $display("FAIL refresh_busy got %0d required 4128", bcyc); end
        checks++; if (lp !== mk_pix(143, 75, 0)) begin failures++; $display("FAIL refresh_last got x=%0d y=%0d required 143,75", lp.x, lp.y); end
        // A second refresh arriving mid-pass must yield exactly one more full pass.
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        push_pass(mem, 1'b1);
        push_pass(mem, 1'b1);
        observe("back_to_back", 12000, 200, -1, mem, 1'b1, plots, bcyc, fp, lp);
        checks++; if (plots != 8192) begin failures++; $display("FAIL back_to_back_plots got %0d required 8192", plots); end
        checks++; if (bcyc != 8256) begin failures++; $display("FAIL back_to_back_busy got %0d required 8256", bcyc); end
        checks++; if (fp !== mk_pix(16, 44, 0)) begin failures++; $display("FAIL back_to_back_first got x=%0d y=%0d required 16,44", fp.x, fp.y); end
    endtask

    task automatic test_mid_pass_change();
        int           plots;
        int           bcyc;
        pix_t         fp;
        pix_t         lp;
        logic [255:0] frame1;
        logic [255:0] frame2;
        frame1 = set_byte(set_byte(mem, 10, 8'hA5), 20, 8'h0F);
        frame2 = set_byte(frame1, 2, 8'h3C);
        mem    = frame1;
        push_pass(frame1, 1'b0);
        push_pass(frame2, 1'b0);
        observe("mid_pass", 2000, -1, 64, frame2, 1'b0, plots, bcyc, fp, lp);
        checks++; if (plots != 384) begin failures++; $display("FAIL mid_pass_plots got %0d required 384", plots); end
        checks++; if (bcyc != 448) begin failures++; $display("FAIL mid_pass_busy got %0d required 448", bcyc); end
        checks++; if (fp !== mk_pix(80, 52, 7)) begin failures++; $display("FAIL mid_pass_first got x=%0d y=%0d c=%0d required 80,52,7", fp.x, fp.y, fp.c); end
        checks++; if (lp !== mk_pix(111, 47, 0)) begin failures++; $display("FAIL mid_pass_last got x=%0d y=%0d c=%0d required 111,47,0", lp.x, lp.y, lp.c); end
    endtask

    task automatic test_reset_mid_draw();
        int   plots;
        int   bcyc;
        pix_t fp;
        pix_t lp;
        bit   seen;
        seen    = 1'b0;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (plot === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL reach_draw got plot=0 required 1 within 100 cycles"); end
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL async_plot got %b required 0", plot); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy got %b required 0", busy); end
        checks++; if (x !== 8'd16 || y !== 7'd44) begin failures++; $display("FAIL async_xy got %0d,%0d required 16,44", x, y); end
        @(negedge clk);
        resetn       = 1'b1;
        model_shadow = '0;
        push_pass(mem, 1'b1);
        observe("post_reset", 6000, -1, -1, mem, 1'b0, plots, bcyc, fp, lp);
        checks++; if (plots != 4096) begin failures++; $display("FAIL post_reset_plots got %0d required 4096", plots); end
        checks++; if (bcyc != 4128) begin failures++; $display("FAIL post_reset_busy got %0d required 4128", bcyc); end
        checks++; if (fp !== mk_pix(16, 44, 0)) begin failures++; $display("FAIL post_reset_first got x=%0d y=%0d required 16,44", fp.x, fp.y); end
    endtask

    task automatic test_last_byte();
        int   plots;
        int   bcyc;
        pix_t fp;
        pix_t lp;
        // Byte 31 flips while byte 5 is rewritten to the value already on screen.
        mem = set_byte(set_byte(mem, 31, 8'hFF), 5, 8'h81);
        push_pass(mem, 1'b0);
        observe("byte31", 1000, -1, -1, mem, 1'b0, plots, bcyc, fp, lp);
        checks++; if (plots != 128) begin failures++; $display("FAIL byte31_plots got %0d required 128", plots); end
        checks++; if (bcyc != 160) begin failures++; $display("FAIL byte31_busy got %0d required 160", bcyc); end
        checks++; if (fp !== mk_pix(112, 72, 7)) begin failures++; $display("FAIL byte31_first got x=%0d y=%0d c=%0d required 112,72,7", fp.x, fp.y, fp.c); end
        checks++; if (lp !== mk_pix(143, 75, 7)) begin failures++; $display("FAIL byte31_last got x=%0d y=%0d c=%0d required 143,75,7", lp.x, lp.y, lp.c); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL byte31_idle got busy=%b required 0", busy); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        resetn       = 1'b0;
        refresh      = 1'b0;
        mem          = '0;
        model_shadow = '0;
        test_reset();
        test_byte_change();
        test_refresh();
        test_mid_pass_change();
        test_reset_mid_draw();
        test_last_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
